// File: rtl/usb_utmi_rx_decoder.sv
// usb_utmi_rx_decoder: UTMI receive decoder that checks PIDs, classifies packets and verifies CRC5/CRC16
// Ports: clk_i/rst_i (async active-high); utmi_* receive stream from the PHY;
//   pid_o/pid_valid_o decoded PID; tok_*/sof_* token fields and strobes;
//   rx_data_o/rx_data_valid_o CRC-stripped payload; hsk_valid_o handshake strobe;
//   pkt_done_o with pkt_len_o/pkt_err_o/pkt_err_code_o end-of-packet status.
module usb_utmi_rx_decoder #(
  parameter int MAX_PAYLOAD = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  utmi_data_in_i,
  input  logic        utmi_rxvalid_i,
  input  logic        utmi_rxactive_i,
  input  logic        utmi_rxerror_i,
  output logic [3:0]  pid_o,
  output logic        pid_valid_o,
  output logic [6:0]  tok_addr_o,
  output logic [3:0]  tok_ep_o,
  output logic        tok_valid_o,
  output logic [10:0] sof_frame_o,
  output logic        sof_valid_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_data_valid_o,
  output logic        hsk_valid_o,
  output logic        pkt_done_o,
  output logic [10:0] pkt_len_o,
  output logic        pkt_err_o,
  output logic [2:0]  pkt_err_code_o
);
  typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DISCARD} state_t;
  localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);
  state_t      state_q, state_d, st;
  logic        first_q;
  logic [1:0]  cnt_q, cnt_d, fill_q, fill_d;
  logic [10:0] fld_q, fld_d, len_q, len_d, plen_q, plen_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, rxd_q, rxd_d;
  logic [3:0]  pid_q, pid_d;
  logic [2:0]  err_q, err_d, err_n, fe, code_q, code_d;
  logic        pidv_q, pidv_d, tokv_q, tokv_d, sofv_q, sofv_d, rxv_q, rxv_d;
  logic        hskv_q, hskv_d, done_q, done_d, perr_q, perr_d;
  logic [7:0]  d;
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[3:0], 1'b0} ^ ((r[4] ^ b[i]) ? 5'h05 : 5'h00);
    return r;
  endfunction
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction
  assign d = utmi_data_in_i;
  always_comb begin
    st = state_q;
    state_d = state_q;
    err_d = err_q;
    cnt_d = cnt_q;
    fill_d = fill_q;
    fld_d = fld_q;
    len_d = len_q;
    crc5_d = crc5_q;
    crc16_d = crc16_q;
    b0_d = b0_q;
    b1_d = b1_q;
    rxd_d = rxd_q;
    pid_d = pid_q;
    plen_d = plen_q;
    code_d = code_q;
    perr_d = perr_q;
    pidv_d = 1'b0;
    tokv_d = 1'b0;
    sofv_d = 1'b0;
    rxv_d = 1'b0;
    hskv_d = 1'b0;
    done_d = 1'b0;
    fe = 3'b000;
    // IDLE folds straight into PID so a PID byte arriving with the rxactive rise is not lost;
    // the first cycle after reset treats an already-active packet as a truncated one.
    if (state_q == S_IDLE) begin
      err_d = {2'b00, first_q && utmi_rxactive_i};
      cnt_d = '0;
      fill_d = '0;
      len_d = '0;
      crc5_d = '1;
      crc16_d = '1;
      st = !utmi_rxactive_i ? S_IDLE : first_q ? S_DISCARD : S_PID;
    end
    err_n = err_d | {2'b00, utmi_rxerror_i};
    if (st != S_IDLE) begin
      if (!utmi_rxactive_i) begin
        fe = st == S_PID   ? err_n | 3'b100 :
             st == S_TOKEN ? err_n | {cnt_q != 2'd2, crc5_q != 5'b01100, 1'b0} :
             st == S_DATA  ? err_n | (cnt_q < 2'd2 ? 3'b110 : {1'b0, crc16_q != 16'h800D, 1'b0}) :
                             err_n;
        done_d = 1'b1;
        perr_d = |fe;
        code_d = fe;
        plen_d = st == S_DATA ? len_q : '0;
        tokv_d = st == S_TOKEN && fe == 3'b000 && (pid_q == 4'h1 || pid_q == 4'h9 || pid_q == 4'hD);
        sofv_d = st == S_TOKEN && fe == 3'b000 && pid_q == 4'h5;
        hskv_d = st == S_HSK && fe == 3'b000;
        state_d = S_IDLE;
      end else if (utmi_rxerror_i) begin
        err_d = err_n;
        state_d = S_DISCARD;
      end else begin
        state_d = st;
        if (utmi_rxvalid_i) begin
          if (st == S_PID) begin
            // PID[1:0] selects the class: 01 token, 11 data, 10 handshake, 00 special (token-shaped)
            if (d[7:4] == ~d[3:0]) begin
              pid_d = d[3:0];
              pidv_d = 1'b1;
              state_d = d[1:0] == 2'b11 ? S_DATA : d[1:0] == 2'b10 ? S_HSK : S_TOKEN;
            end else begin
              err_d = err_n | 3'b001;
              state_d = S_DISCARD;
            end
          end
          if (st == S_TOKEN) begin
            cnt_d = cnt_q == 2'd3 ? cnt_q : cnt_q + 2'd1;
            fld_d = cnt_q == 2'd0 ? {fld_q[10:8], d} : cnt_q == 2'd1 ? {d[2:0], fld_q[7:0]} : fld_q;
            crc5_d = crc5_byte(crc5_q, d);
          end
          if (st == S_DATA) begin
            cnt_d = cnt_q == 2'd3 ? cnt_q : cnt_q + 2'd1;
            crc16_d = crc16_byte(crc16_q, d);
            // Two-byte delay keeps the trailing CRC bytes from ever being emitted
            if (fill_q == 2'd2) begin
              b0_d = b1_q;
              b1_d = d;
              if (!err_q[2]) begin
                if (len_q == MAX_L) begin
                  err_d = err_q | 3'b100;
                end else begin
                  rxd_d = b0_q;
                  rxv_d = 1'b1;
                  len_d = len_q + 11'd1;
                end
              end
            end else begin
              b0_d = fill_q == 2'd0 ? d : b0_q;
              b1_d = fill_q == 2'd1 ? d : b1_q;
              fill_d = fill_q + 2'd1;
            end
          end
          if (st == S_HSK) err_d = err_q | 3'b100;
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      first_q <= 1'b1;
      err_q <= '0;
      cnt_q <= '0;
      fill_q <= '0;
      fld_q <= '0;
      len_q <= '0;
      crc5_q <= '1;
      crc16_q <= '1;
      b0_q <= '0;
      b1_q <= '0;
      rxd_q <= '0;
      pid_q <= '0;
      plen_q <= '0;
      code_q <= '0;
      perr_q <= 1'b0;
      pidv_q <= 1'b0;
      tokv_q <= 1'b0;
      sofv_q <= 1'b0;
      rxv_q <= 1'b0;
      hskv_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      err_q <= err_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      fld_q <= fld_d;
      len_q <= len_d;
      crc5_q <= crc5_d;
      crc16_q <= crc16_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      rxd_q <= rxd_d;
      pid_q <= pid_d;
      plen_q <= plen_d;
      code_q <= code_d;
      perr_q <= perr_d;
      pidv_q <= pidv_d;
      tokv_q <= tokv_d;
      sofv_q <= sofv_d;
      rxv_q <= rxv_d;
      hskv_q <= hskv_d;
      done_q <= done_d;
    end
  end
  assign pid_o = pid_q;
  assign pid_valid_o = pidv_q;
  assign tok_addr_o = fld_q[6:0];
  assign tok_ep_o = fld_q[10:7];
  assign tok_valid_o = tokv_q;
  assign sof_frame_o = fld_q;
  assign sof_valid_o = sofv_q;
  assign rx_data_o = rxd_q;
  assign rx_data_valid_o = rxv_q;
  assign hsk_valid_o = hskv_q;
  assign pkt_done_o = done_q;
  assign pkt_len_o = plen_q;
  assign pkt_err_o = perr_q;
  assign pkt_err_code_o = code_q;
endmodule

// File: tb/tb_usb_utmi_rx_decoder.sv
// tb_usb_utmi_rx_decoder: directed self-checking bench for usb_utmi_rx_decoder
module tb_usb_utmi_rx_decoder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  data = '0;
  logic        rxvalid = 1'b0, rxactive = 1'b0, rxerror = 1'b0;
  logic [3:0]  pid_o, tok_ep_o;
  logic [6:0]  tok_addr_o;
  logic [10:0] sof_frame_o, pkt_len_o;
  logic [7:0]  rx_data_o;
  logic [2:0]  pkt_err_code_o;
  logic        pid_valid_o, tok_valid_o, sof_valid_o, rx_data_valid_o, hsk_valid_o, pkt_done_o, pkt_err_o;
  int total = 0, bad = 0;
  int n_pidv = 0, n_tok = 0, n_sof = 0, n_hsk = 0, n_done = 0;
  int s, p0, t0, f0, h0;
  logic [7:0] got[$];
  logic [7:0] pkt[$];
  logic [7:0] exp_q[$];
  logic [10:0] l_len;
  logic [2:0] l_code;
  logic l_err, l_tok, l_sof, l_hsk;
  usb_utmi_rx_decoder #(.MAX_PAYLOAD(8)) dut (
    .clk_i(clk), .rst_i(rst), .utmi_data_in_i(data), .utmi_rxvalid_i(rxvalid),
    .utmi_rxactive_i(rxactive), .utmi_rxerror_i(rxerror), .pid_o(pid_o), .pid_valid_o(pid_valid_o),
    .tok_addr_o(tok_addr_o), .tok_ep_o(tok_ep_o), .tok_valid_o(tok_valid_o), .sof_frame_o(sof_frame_o),
    .sof_valid_o(sof_valid_o), .rx_data_o(rx_data_o), .rx_data_valid_o(rx_data_valid_o),
    .hsk_valid_o(hsk_valid_o), .pkt_done_o(pkt_done_o), .pkt_len_o(pkt_len_o), .pkt_err_o(pkt_err_o),
    .pkt_err_code_o(pkt_err_code_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_data_valid_o) got.push_back(rx_data_o);
    if (pid_valid_o) n_pidv++;
    if (tok_valid_o) n_tok++;
    if (sof_valid_o) n_sof++;
    if (hsk_valid_o) n_hsk++;
    if (pkt_done_o) begin
      n_done++;
      l_len = pkt_len_o;
      l_code = pkt_err_code_o;
      l_err = pkt_err_o;
      l_tok = tok_valid_o;
      l_sof = sof_valid_o;
      l_hsk = hsk_valid_o;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    s = got.size();
    p0 = n_pidv;
    t0 = n_tok;
    f0 = n_sof;
    h0 = n_hsk;
  endtask
  task automatic rise();
    @(posedge clk); #1 rxactive = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic bytes(input int gap);
    foreach (pkt[i]) begin
      data = pkt[i];
      rxvalid = 1'b1;
      @(posedge clk); #1 rxvalid = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
  endtask
  task automatic finish_pkt();
    int d0;
    rxactive = 1'b0;
    d0 = n_done;
    for (int k = 0; k < 10 && n_done == d0; k++) @(posedge clk);
    chk("pkt_done", 32'(n_done - d0), 1);
  endtask
  task automatic send(input int gap);
    snap();
    rise();
    bytes(gap);
    finish_pkt();
  endtask
  task automatic chk_got(input string tag);
    chk({tag, "_count"}, 32'(got.size() - s), 32'(exp_q.size()));
    foreach (exp_q[i]) chk(tag, (s + i < got.size()) ? 32'(got[s + i]) : 'x, 32'(exp_q[i]));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pid", 32'(pid_o), 0);
    chk("rst_done", 32'(pkt_done_o), 0);
    chk("rst_rxv", 32'(rx_data_valid_o), 0);
    chk("rst_len", 32'(pkt_len_o), 0);
    // SETUP token, address 0 endpoint 0
    pkt = '{8'h2D, 8'h00, 8'h10};
    send(0);
    chk("setup_pid", 32'(pid_o), 32'hD);
    chk("setup_pidv", 32'(n_pidv - p0), 1);
    chk("setup_tokv", 32'(n_tok - t0), 1);
    chk("setup_tok_with_done", 32'(l_tok), 1);
    chk("setup_addr", 32'(tok_addr_o), 0);
    chk("setup_ep", 32'(tok_ep_o), 0);
    chk("setup_err", 32'(l_err), 0);
    chk("setup_len", 32'(l_len), 0);
    // SOF frame 0, straight after the previous packet
    pkt = '{8'hA5, 8'h00, 8'h10};
    send(0);
    chk("sof_valid", 32'(n_sof - f0), 1);
    chk("sof_with_done", 32'(l_sof), 1);
    chk("sof_frame", 32'(sof_frame_o), 0);
    chk("sof_tokv", 32'(n_tok - t0), 0);
    // DATA0 GET_DESCRIPTOR with rxvalid gaps; payload equals MAX_PAYLOAD
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    exp_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    send(1);
    chk_got("desc_byte");
    chk("desc_len", 32'(l_len), 8);
    chk("desc_code", 32'(l_code), 0);
    chk("desc_pid", 32'(pid_o), 32'h3);
    // zero-length DATA1, good then bad CRC
    pkt = '{8'h4B, 8'h00, 8'h00};
    send(0);
    chk("zlp_strobes", 32'(got.size() - s), 0);
    chk("zlp_len", 32'(l_len), 0);
    chk("zlp_code", 32'(l_code), 0);
    pkt = '{8'h4B, 8'h00, 8'h01};
    send(0);
    chk("zlp_badcrc_code", 32'(l_code), 32'b010);
    chk("zlp_badcrc_err", 32'(l_err), 1);
    // bad PID, then ACK
    pkt = '{8'hC4};
    send(0);
    chk("badpid_pidv", 32'(n_pidv - p0), 0);
    chk("badpid_code", 32'(l_code), 32'b001);
    pkt = '{8'hD2};
    send(0);
    chk("ack_hsk", 32'(n_hsk - h0), 1);
    chk("ack_with_done", 32'(l_hsk), 1);
    chk("ack_pid", 32'(pid_o), 32'h2);
    chk("ack_code", 32'(l_code), 0);
    // handshake followed by an extra byte
    pkt = '{8'h5A, 8'h00};
    send(0);
    chk("nak_extra_hsk", 32'(n_hsk - h0), 0);
    chk("nak_extra_code", 32'(l_code), 32'b100);
    // empty packet, short token, bad token CRC, short data
    pkt = {};
    send(0);
    chk("empty_code", 32'(l_code), 32'b100);
    pkt = '{8'h2D, 8'h00};
    send(0);
    chk("short_tok_code", 32'(l_code), 32'b110);
    chk("short_tok_tokv", 32'(n_tok - t0), 0);
    pkt = '{8'h2D, 8'h00, 8'h11};
    send(0);
    chk("badcrc_tok_code", 32'(l_code), 32'b010);
    chk("badcrc_tok_tokv", 32'(n_tok - t0), 0);
    pkt = '{8'hC3, 8'h55};
    send(0);
    chk("short_data_code", 32'(l_code), 32'b110);
    chk("short_data_strobes", 32'(got.size() - s), 0);
    // PHY error in the middle of a DATA0 payload
    snap();
    rise();
    pkt = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
    bytes(0);
    rxerror = 1'b1;
    @(posedge clk); #1 rxerror = 1'b0;
    pkt = '{8'h55, 8'h66, 8'h77};
    bytes(0);
    finish_pkt();
    exp_q = '{8'h11, 8'h22};
    chk_got("phyerr_byte");
    chk("phyerr_code", 32'(l_code), 32'b001);
    chk("phyerr_pidv", 32'(n_pidv - p0), 1);
    chk("phyerr_others", 32'((n_tok - t0) + (n_sof - f0) + (n_hsk - h0)), 0);
    // payload one byte beyond MAX_PAYLOAD
    pkt = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00, 8'h00};
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send(0);
    chk_got("ovf_byte");
    chk("ovf_len", 32'(l_len), 8);
    chk("ovf_bit2", 32'(l_code[2]), 1);
    // reset in the middle of a packet
    rise();
    pkt = '{8'hC3, 8'h11, 8'h22, 8'h33};
    bytes(0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pid", 32'(pid_o), 0);
    chk("midrst_rxd", 32'(rx_data_o), 0);
    chk("midrst_len", 32'(pkt_len_o), 0);
    chk("midrst_code", 32'(pkt_err_code_o), 0);
    snap();
    @(posedge clk); #1 rst = 1'b0;
    pkt = '{8'h44, 8'h55};
    bytes(0);
    finish_pkt();
    chk("postrst_code", 32'(l_code), 32'b001);
    chk("postrst_err", 32'(l_err), 1);
    chk("postrst_strobes", 32'(got.size() - s), 0);
    chk("postrst_pidv", 32'(n_pidv - p0), 0);
    // decoder recovers for a normal token afterwards
    pkt = '{8'h2D, 8'h00, 8'h10};
    send(0);
    chk("recover_tokv", 32'(n_tok - t0), 1);
    chk("recover_code", 32'(l_code), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
